// File: rtl/ctrl_pipe_sched_if.sv
// ctrl_pipe_sched_if: instruction-in / control-word-out bundle for ctrl_pipe_sched.
//   in_valid, instruction : fetch side offers an instruction
//   in_ready              : scheduler takes it this cycle when in_valid && in_ready
//   ex_cw/mem_cw/wb_cw    : 22-bit control words held in the EX/MEM/WB slots
//   ex_busy               : multi-cycle mul is holding EX
//   illegal               : one-cycle pulse after an undecodable instruction is taken
// master = fetch/datapath side, slave = scheduler.
interface ctrl_pipe_sched_if;
   logic        in_valid;
   logic [31:0] instruction;
   logic        in_ready;
   logic [21:0] ex_cw;
   logic [21:0] mem_cw;
   logic [21:0] wb_cw;
   logic        ex_busy;
   logic        illegal;

   modport master (output in_valid, instruction,
                   input  in_ready, ex_cw, mem_cw, wb_cw, ex_busy, illegal);
   modport slave  (input  in_valid, instruction,
                   output in_ready, ex_cw, mem_cw, wb_cw, ex_busy, illegal);
endinterface

// File: rtl/ctrl_pipe_sched.sv
// ctrl_pipe_sched: decodes 32-bit instructions into 22-bit control words and
// issues them through registered EX/MEM/WB slots, stalling the front end on
// read-after-write hazards and while a multi-cycle mul occupies EX.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : ctrl_pipe_sched_if.slave (instruction in, stage control words out)
module ctrl_pipe_sched #(
   parameter int MUL_CYCLES = 2,
   parameter bit WB_BYPASS  = 1'b0,
   parameter bit TRACK_R0   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   ctrl_pipe_sched_if.slave bus
);
   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef struct packed {
      logic [4:0] src_a;
      logic [4:0] src_b;
      logic       mux_b_imm;
      logic       mux_alu_mul;
      logic [1:0] alu_op;
      logic       mem_wr;
      logic       wb_mem;
      logic [4:0] dest;
      logic       write_rf;
   } cw_t;

   cw_t             ex_q, mem_q, wb_q;
   logic [CNT_W-1:0] mul_cnt;
   logic            illegal_q;

   cw_t  dec_cw;
   logic dec_legal, use_a, use_b;
   logic hazard, ex_busy, accept;

   logic [5:0] opcode, funct;
   assign opcode = bus.instruction[31:26];
   assign funct  = bus.instruction[5:0];

   // shamt-position bits carry no meaning in this ISA
   logic unused_bits;
   assign unused_bits = ^bus.instruction[10:6];

   always_comb begin
      dec_cw    = '0;
      dec_legal = 1'b1;
      use_a     = 1'b0;
      use_b     = 1'b0;
      case (opcode)
         6'b000001: begin
            dec_cw.src_a     = bus.instruction[25:21];
            dec_cw.src_b     = bus.instruction[20:16];
            dec_cw.dest      = bus.instruction[15:11];
            dec_cw.mux_b_imm = 1'b1;
            dec_cw.write_rf  = 1'b1;
            use_a            = 1'b1;
            use_b            = 1'b1;
            case (funct)
               6'd32: dec_cw.alu_op = 2'b00;
               6'd34: dec_cw.alu_op = 2'b01;
               6'd36: dec_cw.alu_op = 2'b10;
               6'd37: dec_cw.alu_op = 2'b11;
               6'd50: dec_cw.mux_alu_mul = 1'b1;
               6'd31: begin
                  dec_cw = '0;
                  use_a  = 1'b0;
                  use_b  = 1'b0;
               end
               default: begin
                  dec_cw    = '0;
                  dec_legal = 1'b0;
                  use_a     = 1'b0;
                  use_b     = 1'b0;
               end
            endcase
         end
         6'b000010: begin
            dec_cw.src_a    = bus.instruction[25:21];
            dec_cw.dest     = bus.instruction[20:16];
            dec_cw.wb_mem   = 1'b1;
            dec_cw.write_rf = 1'b1;
            use_a           = 1'b1;
         end
         6'b000011: begin
            dec_cw.src_a  = bus.instruction[25:21];
            dec_cw.src_b  = bus.instruction[20:16];
            dec_cw.mem_wr = 1'b1;
            use_a         = 1'b1;
            use_b         = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
      // r0 is hardwired zero: a write to it is dropped at decode
      if (!TRACK_R0 && dec_cw.dest == 5'd0)
         dec_cw.write_rf = 1'b0;
   end

   function automatic logic slot_hit(input logic [4:0] src, input cw_t slot);
      return slot.write_rf && (slot.dest == src) && (TRACK_R0 || src != 5'd0);
   endfunction

   function automatic logic src_hit(input logic [4:0] src);
      return slot_hit(src, ex_q) || slot_hit(src, mem_q) ||
             (!WB_BYPASS && slot_hit(src, wb_q));
   endfunction

   assign hazard  = bus.in_valid &&
                    ((use_a && src_hit(dec_cw.src_a)) || (use_b && src_hit(dec_cw.src_b)));
   assign ex_busy = (mul_cnt != '0);
   assign accept  = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         mul_cnt   <= '0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= accept && !dec_legal;
         wb_q      <= mem_q;
         if (ex_busy) begin
            // mul still computing: EX holds, MEM sees bubbles
            mem_q   <= '0;
            mul_cnt <= mul_cnt - CNT_W'(1);
         end else begin
            mem_q <= ex_q;
            ex_q  <= accept ? dec_cw : '0;
            if (accept && dec_cw.mux_alu_mul && MUL_CYCLES > 1)
               mul_cnt <= CNT_W'(MUL_CYCLES - 1);
         end
      end
   end

   assign bus.in_ready = rst_n && !hazard && !ex_busy;
   assign bus.ex_cw    = ex_q;
   assign bus.mem_cw   = mem_q;
   assign bus.wb_cw    = wb_q;
   assign bus.ex_busy  = ex_busy;
   assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_ctrl_pipe_sched.sv
module tb_ctrl_pipe_sched;
   localparam int MC0 = 3, BY0 = 0, TR0 = 0;
   localparam int MC1 = 2, BY1 = 1, TR1 = 1;
   localparam int MC[2] = '{MC0, MC1};
   localparam int BY[2] = '{BY0, BY1};
   localparam int TR[2] = '{TR0, TR1};

   localparam logic [31:0] ADD    = 32'h04221AA0; // r3 = r1 + r2
   localparam logic [31:0] SUB    = 32'h046122A2; // r4 = r3 - r1
   localparam logic [31:0] MUL    = 32'h04223832; // r7 = r1 * r2
   localparam logic [31:0] ADD2   = 32'h04A64020; // r8 = r5 + r6
   localparam logic [31:0] LOAD   = 32'h08250000; // r5 = mem[r1]
   localparam logic [31:0] STORE  = 32'h0C450000; // mem[r2] = r5
   localparam logic [31:0] ADDR2  = 32'h04424820; // r9 = r2 + r2
   localparam logic [31:0] ILL    = 32'hFC000000;
   localparam logic [31:0] ADD0   = 32'h04220020; // r0 = r1 + r2
   localparam logic [31:0] R0READ = 32'h04005020; // r10 = r0 + r0
   localparam logic [31:0] DEP    = 32'h04E75820; // r11 = r7 + r7

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   int          checks = 0;
   int          failures = 0;
   bit          cmp_en = 1'b0;

   always #5 clk = ~clk;

   ctrl_pipe_sched_if if0 ();
   ctrl_pipe_sched_if if1 ();
   assign if0.in_valid = in_valid;
   assign if0.instruction = instr;
   assign if1.in_valid = in_valid;
   assign if1.instruction = instr;

   ctrl_pipe_sched #(.MUL_CYCLES(MC0), .WB_BYPASS(BY0 != 0), .TRACK_R0(TR0 != 0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   ctrl_pipe_sched #(.MUL_CYCLES(MC1), .WB_BYPASS(BY1 != 0), .TRACK_R0(TR1 != 0))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   logic [21:0] d_ex[2], d_mem[2], d_wb[2];
   logic        d_busy[2], d_ill[2], d_rdy[2];
   assign d_ex[0] = if0.ex_cw;   assign d_ex[1] = if1.ex_cw;
   assign d_mem[0] = if0.mem_cw; assign d_mem[1] = if1.mem_cw;
   assign d_wb[0] = if0.wb_cw;   assign d_wb[1] = if1.wb_cw;
   assign d_busy[0] = if0.ex_busy; assign d_busy[1] = if1.ex_busy;
   assign d_ill[0] = if0.illegal;  assign d_ill[1] = if1.illegal;
   assign d_rdy[0] = if0.in_ready; assign d_rdy[1] = if1.in_ready;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d got=%h want=%h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [21:0] m_ex[2], m_mem[2], m_wb[2];
   int          m_hold[2];
   bit          m_ill[2];
   initial for (int k = 0; k < 2; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_hold[k] = 0; m_ill[k] = 0;
   end

   // Decode by mnemonic; fields assembled arithmetically into the word.
   function automatic void mdec(input logic [31:0] i, input int trk, output logic [21:0] cw,
                                output bit legal, output bit ua, output bit ub);
      int op, fn, a, b, d;
      int alu, mux, mul, mw, wm, w, sa, sb, dst;
      op = int'(i[31:26]); fn = int'(i[5:0]);
      a = int'(i[25:21]); b = int'(i[20:16]); d = int'(i[15:11]);
      alu = 0; mux = 0; mul = 0; mw = 0; wm = 0; w = 0; sa = 0; sb = 0; dst = 0;
      legal = 1; ua = 0; ub = 0;
      if (op == 1 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 50)) begin
         alu = (fn == 34) ? 1 : (fn == 36) ? 2 : (fn == 37) ? 3 : 0;
         mul = (fn == 50) ? 1 : 0;
         mux = 1; w = 1; sa = a; sb = b; dst = d; ua = 1; ub = 1;
      end else if (op == 1 && fn == 31) begin
         legal = 1;
      end else if (op == 2) begin
         sa = a; dst = b; wm = 1; w = 1; ua = 1;
      end else if (op == 3) begin
         sa = a; sb = b; mw = 1; ua = 1; ub = 1;
      end else begin
         legal = 0;
      end
      if (trk == 0 && dst == 0) w = 0;
      cw = 22'(sa * 131072 + sb * 4096 + mux * 2048 + mul * 1024 + alu * 256 +
               mw * 128 + wm * 64 + dst * 2 + w);
   endfunction

   function automatic bit m_ready(input int k);
      logic [21:0] cw, sl;
      bit lg, ua, ub, hz;
      int sa, sb;
      mdec(instr, TR[k], cw, lg, ua, ub);
      sa = int'(cw[21:17]); sb = int'(cw[16:12]);
      hz = 0;
      if (in_valid) begin
         for (int s = 0; s < 3; s++) begin
            sl = (s == 0) ? m_ex[k] : (s == 1) ? m_mem[k] : m_wb[k];
            if (!(s == 2 && BY[k] != 0) && sl[0]) begin
               if (ua && int'(sl[5:1]) == sa && (TR[k] != 0 || sa != 0)) hz = 1;
               if (ub && int'(sl[5:1]) == sb && (TR[k] != 0 || sb != 0)) hz = 1;
            end
         end
      end
      return rst_n && m_hold[k] == 0 && !hz;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [21:0] cw;
         bit lg, ua, ub, acc;
         acc = in_valid && m_ready(k);
         mdec(instr, TR[k], cw, lg, ua, ub);
         if (!rst_n) begin
            m_ex[k] <= '0; m_mem[k] <= '0; m_wb[k] <= '0; m_hold[k] <= 0; m_ill[k] <= 0;
         end else begin
            m_ill[k] <= acc && !lg;
            m_wb[k]  <= m_mem[k];
            if (m_hold[k] > 0) begin
               m_mem[k]  <= '0;
               m_hold[k] <= m_hold[k] - 1;
            end else begin
               m_mem[k]  <= m_ex[k];
               m_ex[k]   <= acc ? cw : 22'd0;
               m_hold[k] <= (acc && cw[10] && MC[k] > 1) ? MC[k] - 1 : 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("m_ex",    k, 32'(d_ex[k]),  32'(m_ex[k]));
            chk("m_mem",   k, 32'(d_mem[k]), 32'(m_mem[k]));
            chk("m_wb",    k, 32'(d_wb[k]),  32'(m_wb[k]));
            chk("m_busy",  k, 32'(d_busy[k]), 32'(m_hold[k] > 0));
            chk("m_ill",   k, 32'(d_ill[k]), 32'(m_ill[k]));
            chk("m_ready", k, 32'(d_rdy[k]), 32'(m_ready(k)));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cyc();
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [4:0] a, b, d;
      logic [5:0] fn, op;
      int sel;
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      d = 5'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      case (sel)
         0, 1, 2: begin
            case ($urandom_range(0, 3))
               0: fn = 6'd32;
               1: fn = 6'd34;
               2: fn = 6'd36;
               default: fn = 6'd37;
            endcase
            return {6'd1, a, b, d, 5'd0, fn};
         end
         3: return {6'd1, a, b, d, 5'd0, 6'd50};
         4: return {6'd1, a, b, d, 5'd0, 6'd31};
         5: return {6'd2, a, b, 16'($urandom)};
         6: return {6'd3, a, b, 16'($urandom)};
         7: begin
            op = 6'($urandom_range(4, 63));
            return {op, 26'($urandom)};
         end
         8: return {6'd1, a, b, d, 5'd0, 6'd33};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int s0, s1, nb, memnz;
      #2_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1, nb, memnz;
      rst_n = 1'b0; in_valid = 1'b0; instr = '0;
      repeat (2) cyc();
      cmp_en = 1'b1;
      @(negedge clk);
      chk("rst_ex", 0, 32'(if0.ex_cw), 32'h0);
      chk("rst_wb", 0, 32'(if0.wb_cw), 32'h0);
      chk("rst_ready", 0, 32'(if0.in_ready), 32'h0);
      chk("rst_busy", 0, 32'(if0.ex_busy), 32'h0);

      // single add
      cyc(); rst_n = 1'b1; in_valid = 1'b1; instr = ADD;
      @(negedge clk); chk("add_ready", 0, 32'(if0.in_ready), 32'h1);
      cyc(); in_valid = 1'b0;
      @(negedge clk); chk("add_ex", 0, 32'(if0.ex_cw), 32'h022807);
      cyc(); @(negedge clk); chk("add_mem", 0, 32'(if0.mem_cw), 32'h022807);
      cyc(); @(negedge clk); chk("add_wb", 0, 32'(if0.wb_cw), 32'h022807);

      // RAW stall: add then dependent sub
      idle(2);
      in_valid = 1'b1; instr = ADD;
      cyc(); instr = SUB;
      s0 = 0; s1 = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (!if1.in_ready) s1++;
         if (if0.in_ready) break;
         s0++;
         cyc();
      end
      chk("raw_stall_nobyp", 0, 32'(s0), 32'd3);
      chk("raw_stall_byp", 1, 32'(s1), 32'd2);
      cyc(); in_valid = 1'b0;
      @(negedge clk); chk("sub_ex", 0, 32'(if0.ex_cw), 32'h061909);

      // multi-cycle mul then independent add
      idle(4);
      in_valid = 1'b1; instr = MUL;
      cyc(); instr = ADD2;
      nb = 0; memnz = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (!if0.ex_busy) break;
         nb++;
         if (if0.mem_cw != '0) memnz++;
         cyc();
      end
      chk("mul_busy_cycles", 0, 32'(nb), 32'd2);
      chk("mul_mem_bubbles", 0, 32'(memnz), 32'd0);
      chk("mul_ex_held", 0, 32'(if0.ex_cw), 32'h022C0F);
      chk("mul_ready_after", 0, 32'(if0.in_ready), 32'h1);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      chk("add2_ex", 0, 32'(if0.ex_cw), 32'h0A6811);
      chk("mul_mem", 0, 32'(if0.mem_cw), 32'h022C0F);

      // load -> store reading the loaded reg stalls; store -> reader does not
      idle(4);
      in_valid = 1'b1; instr = LOAD;
      cyc(); instr = STORE;
      s0 = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (if0.in_ready) break;
         s0++;
         cyc();
      end
      chk("load_store_stall", 0, 32'(s0), 32'd3);
      cyc(); instr = ADDR2;
      @(negedge clk); chk("store_no_hazard", 0, 32'(if0.in_ready), 32'h1);
      cyc(); in_valid = 1'b0;

      // illegal opcode
      idle(4);
      in_valid = 1'b1; instr = ILL;
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      chk("ill_pulse", 0, 32'(if0.illegal), 32'h1);
      chk("ill_ex", 0, 32'(if0.ex_cw), 32'h0);
      cyc(); @(negedge clk); chk("ill_clear", 0, 32'(if0.illegal), 32'h0);

      // r0 handling
      idle(4);
      in_valid = 1'b1; instr = ADD0;
      cyc(); instr = R0READ;
      @(negedge clk);
      chk("r0_ex_nowrite", 0, 32'(if0.ex_cw), 32'h022800);
      chk("r0_reader_ready", 0, 32'(if0.in_ready), 32'h1);
      chk("r0_tracked_ex", 1, 32'(if1.ex_cw), 32'h022801);
      chk("r0_tracked_stall", 1, 32'(if1.in_ready), 32'h0);
      cyc(); in_valid = 1'b0;

      // reset during mul hold with a pending dependent instruction
      idle(4);
      in_valid = 1'b1; instr = MUL;
      cyc(); instr = DEP;
      @(negedge clk);
      chk("pre_rst_busy", 0, 32'(if0.ex_busy), 32'h1);
      chk("pre_rst_ready", 0, 32'(if0.in_ready), 32'h0);
      cyc(); rst_n = 1'b0;
      cyc(); rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ex", 0, 32'(if0.ex_cw), 32'h0);
      chk("midrst_mem", 0, 32'(if0.mem_cw), 32'h0);
      chk("midrst_busy", 0, 32'(if0.ex_busy), 32'h0);
      chk("midrst_ill", 0, 32'(if0.illegal), 32'h0);
      chk("midrst_ready", 0, 32'(if0.in_ready), 32'h1);
      cyc(); in_valid = 1'b0;
      @(negedge clk); chk("dep_ex", 0, 32'(if0.ex_cw), 32'h0E7817);

      // randomized traffic against the model
      repeat (3000) begin
         cyc();
         rst_n = ($urandom_range(0, 299) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         instr = rnd_instr();
      end
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
